// File: rtl/booth_pkg.sv
// booth_pkg: shared types and digit-count helper for the radix-4 Booth multiplier
package booth_pkg;
  typedef struct packed {
    logic neg;
    logic two;
    logic zero;
  } booth_enc_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  function automatic int digits(input int width, input logic sgn);
    return sgn ? width / 2 : width / 2 + 1;
  endfunction
endpackage

// File: rtl/booth_r4_digit_enc.sv
// booth_r4_digit_enc: radix-4 Booth triplet to {neg, two, zero}
module booth_r4_digit_enc
  import booth_pkg::*;
(
  input  logic [2:0]  trip_i,
  output booth_enc_t  enc_o
);
  assign enc_o.zero = (trip_i == 3'b000) | (trip_i == 3'b111);
  assign enc_o.neg  = trip_i[2] & ~(trip_i[1] & trip_i[0]);
  assign enc_o.two  = (trip_i == 3'b011) | (trip_i == 3'b100);
endmodule

// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult: iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);
  localparam int AW = 2 * WIDTH + 4;
  localparam int CW = $clog2(WIDTH / 2 + 2);
  state_e              state_q, state_d;
  logic                sgn_q;
  logic [WIDTH+1:0]    m_q;
  logic [WIDTH+2:0]    b_q;
  logic [AW-1:0]       acc_q, acc_nx;
  logic [CW-1:0]       cnt_q;
  logic [2*WIDTH-1:0]  p_q;
  logic [WIDTH+3:0]    pp, sum;
  logic                accept, last;
  booth_enc_t          enc;
  booth_r4_digit_enc u_enc (.trip_i(b_q[2:0]), .enc_o(enc));
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign last      = cnt_q == CW'(digits(WIDTH, sgn_q) - 1);
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_p     = p_q;
  always_comb begin
    pp  = enc.zero ? '0 : enc.two ? {m_q[WIDTH+1], m_q, 1'b0} : {{2{m_q[WIDTH+1]}}, m_q};
    sum = acc_q[AW-1 -: WIDTH+4] + (enc.neg ? ~pp : pp) + {{(WIDTH+3){1'b0}}, enc.neg};
    // The unsigned-only top digit lands at weight 2^WIDTH directly, so it is added without a shift
    acc_nx = (cnt_q < CW'(WIDTH / 2)) ? {{2{sum[WIDTH+3]}}, sum, acc_q[WIDTH-1:2]}
                                      : {sum, acc_q[WIDTH-1:0]};
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? CALC : IDLE;
      CALC:    state_d = last ? DONE : CALC;
      DONE:    state_d = accept ? CALC : out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sgn_q   <= 1'b0;
      m_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sgn_q <= in_signed;
        m_q   <= {{2{in_signed & in_a[WIDTH-1]}}, in_a};
        b_q   <= {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state_q == CALC) begin
        acc_q <= acc_nx;
        b_q   <= b_q >> 2;
        cnt_q <= cnt_q + CW'(1);
        if (last) p_q <= acc_nx[2*WIDTH-1:0];
      end
    end
  end
endmodule
